// File: rtl/pattern_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : pattern_counter_if
// Brief    : Control/observation bundle between the game FSM and pattern_counter.
// Revision : 1.0
// ============================================================================
interface pattern_counter_if #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 16
);
    logic                      hold;
    logic [1:0]                mode;
    logic                      load;
    logic [WIDTH-1:0]          load_val;
    logic [WIDTH-1:0]          max_val;
    logic [PRESCALE_W-1:0]     prescale_div;
    logic [WIDTH-1:0]          count;
    logic [WIDTH*CHANNELS-1:0] colors;
    logic                      dir;
    logic                      tc;

    modport master (
        output hold, mode, load, load_val, max_val, prescale_div,
        input  count, colors, dir, tc
    );

    modport slave (
        input  hold, mode, load, load_val, max_val, prescale_div,
        output count, colors, dir, tc
    );
endinterface
`default_nettype wire

// File: rtl/pattern_counter.sv
`default_nettype none
// ============================================================================
// Module   : pattern_counter
// Brief    : Prescaled up/down/bounce/LFSR pattern counter fanned out to lanes.
// Revision : 1.0
// ============================================================================
module pattern_counter #(
    parameter int               WIDTH      = 8,
    parameter int               CHANNELS   = 4,
    parameter int               STRIDE     = 0,
    parameter int               PRESCALE_W = 16,
    parameter logic [WIDTH-1:0] LFSR_TAPS  = 8'hB8
) (
    input  wire logic           clk,
    input  wire logic           reset,
    pattern_counter_if.slave    bus
);

    localparam logic [WIDTH-1:0]      c_ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0]      c_ZERO     = '0;
    localparam logic [PRESCALE_W-1:0] c_PSC_ONE  = PRESCALE_W'(1);

    localparam logic [1:0] c_MODE_UP     = 2'd0;
    localparam logic [1:0] c_MODE_DOWN   = 2'd1;
    localparam logic [1:0] c_MODE_BOUNCE = 2'd2;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    logic [WIDTH-1:0]          count_q, count_d;
    dir_e                      dir_q, dir_d;
    logic                      tc_q, tc_d;
    logic [PRESCALE_W-1:0]     psc_q, psc_d;
    logic                      w_tick;
    logic [WIDTH-1:0]          w_lfsr_next;
    logic [WIDTH*CHANNELS-1:0] w_colors;

    assign w_tick      = (psc_q == bus.prescale_div);
    assign w_lfsr_next = (count_q >> 1) ^ (count_q[0] ? LFSR_TAPS : c_ZERO);

    always_comb begin
        // psc above a freshly lowered divider wraps without producing a tick
        if (bus.load || (psc_q >= bus.prescale_div)) begin
            psc_d = '0;
        end else begin
            psc_d = psc_q + c_PSC_ONE;
        end
    end

    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        tc_d    = 1'b0;
        if (bus.load) begin
            count_d = bus.load_val;
        end else if (!bus.hold && w_tick) begin
            if (bus.mode == 2'd3) begin
                if (count_q == c_ZERO) begin
                    count_d = c_ONE;
                end else begin
                    count_d = w_lfsr_next;
                    tc_d    = (w_lfsr_next == c_ONE);
                end
            end else if (bus.max_val == c_ZERO) begin
                count_d = c_ZERO;
                tc_d    = 1'b1;
            end else begin
                case (bus.mode)
                    c_MODE_UP: begin
                        if (count_q >= bus.max_val) begin
                            count_d = c_ZERO;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = count_q + c_ONE;
                        end
                    end
                    c_MODE_DOWN: begin
                        if (count_q == c_ZERO) begin
                            count_d = bus.max_val;
                            tc_d    = 1'b1;
                        end else if (count_q > bus.max_val) begin
                            count_d = bus.max_val;
                        end else begin
                            count_d = count_q - c_ONE;
                        end
                    end
                    c_MODE_BOUNCE: begin
                        if (dir_q == DIR_UP) begin
                            if (count_q >= bus.max_val) begin
                                dir_d   = DIR_DOWN;
                                count_d = count_q - c_ONE;
                                tc_d    = 1'b1;
                            end else begin
                                count_d = count_q + c_ONE;
                            end
                        end else begin
                            if (count_q == c_ZERO) begin
                                dir_d   = DIR_UP;
                                count_d = c_ONE;
                                tc_d    = 1'b1;
                            end else begin
                                count_d = count_q - c_ONE;
                            end
                        end
                    end
                    default: begin
                        count_d = count_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            dir_q   <= DIR_UP;
            tc_q    <= 1'b0;
            psc_q   <= '0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            tc_q    <= tc_d;
            psc_q   <= psc_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        localparam logic [WIDTH-1:0] c_OFFSET = WIDTH'(i * STRIDE);
        assign w_colors[i*WIDTH +: WIDTH] = count_q + c_OFFSET;
    end

    assign bus.count  = count_q;
    assign bus.dir    = dir_q;
    assign bus.tc     = tc_q;
    assign bus.colors = w_colors;

endmodule
`default_nettype wire

// File: tb/tb_pattern_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_counter
// Brief    : Scoreboard bench for pattern_counter (STRIDE=3, 4 lanes, 8 bits).
// Revision : 1.0
// ============================================================================
module tb_pattern_counter;

    localparam int          c_W    = 8;
    localparam int          c_CH   = 4;
    localparam int          c_ST   = 3;
    localparam int          c_PW   = 16;
    localparam logic [7:0]  c_TAPS = 8'hB8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pattern_counter_if #(.WIDTH(c_W), .CHANNELS(c_CH), .PRESCALE_W(c_PW)) bus ();

    pattern_counter #(
        .WIDTH(c_W), .CHANNELS(c_CH), .STRIDE(c_ST),
        .PRESCALE_W(c_PW), .LFSR_TAPS(c_TAPS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct packed {
        logic [7:0] cnt;
        logic       dir;
        logic       tc;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  m_cnt;
    logic        m_dir;
    logic [15:0] m_psc;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lanes_of(input logic [7:0] c);
        logic [31:0] r;
        for (int i = 0; i < c_CH; i++) r[i*8 +: 8] = c + 8'(i * c_ST);
        return r;
    endfunction

    task automatic model_reset();
        m_cnt = 8'h00;
        m_dir = 1'b1;
        m_psc = 16'h0;
        sb_q.delete();
    endtask

    // Reference behaviour for the coming edge, from the inputs now on the bus.
    task automatic predict();
        exp_t       e;
        logic       tick;
        logic [7:0] mx;
        tick  = (m_psc == bus.prescale_div);
        mx    = bus.max_val;
        e.cnt = m_cnt;
        e.dir = m_dir;
        e.tc  = 1'b0;
        if (bus.load) begin
            e.cnt = bus.load_val;
        end else if (!bus.hold && tick) begin
            if (bus.mode == 2'd3) begin
                if (m_cnt == 8'h00) e.cnt = 8'h01;
                else begin
                    e.cnt = {1'b0, m_cnt[7:1]} ^ (m_cnt[0] ? c_TAPS : 8'h00);
                    e.tc  = (e.cnt == 8'h01);
                end
            end else if (mx == 8'h00) begin
                e.cnt = 8'h00;
                e.tc  = 1'b1;
            end else if (bus.mode == 2'd0) begin
                if (m_cnt >= mx) begin e.cnt = 8'h00; e.tc = 1'b1; end
                else e.cnt = m_cnt + 8'd1;
            end else if (bus.mode == 2'd1) begin
                if (m_cnt == 8'h00) begin e.cnt = mx; e.tc = 1'b1; end
                else if (m_cnt > mx) e.cnt = mx;
                else e.cnt = m_cnt - 8'd1;
            end else if (m_dir) begin
                if (m_cnt >= mx) begin e.cnt = m_cnt - 8'd1; e.dir = 1'b0; e.tc = 1'b1; end
                else e.cnt = m_cnt + 8'd1;
            end else begin
                if (m_cnt == 8'h00) begin e.cnt = 8'h01; e.dir = 1'b1; e.tc = 1'b1; end
                else e.cnt = m_cnt - 8'd1;
            end
        end
        if (bus.load || m_psc >= bus.prescale_div) m_psc = 16'h0;
        else m_psc = m_psc + 16'd1;
        m_cnt = e.cnt;
        m_dir = e.dir;
        sb_q.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        predict();
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("count",  64'(bus.count),  64'(e.cnt));
        check("dir",    64'(bus.dir),    64'(e.dir));
        check("tc",     64'(bus.tc),     64'(e.tc));
        check("colors", 64'(bus.colors), 64'(lanes_of(e.cnt)));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        logic [7:0] held;
        int         tcs;

        bus.hold = 1'b0; bus.mode = 2'd0; bus.load = 1'b0;
        bus.load_val = 8'h00; bus.max_val = 8'h00; bus.prescale_div = 16'd0;
        reset = 1'b1;
        model_reset();
        #2;
        check("rst_count",  64'(bus.count),  64'h0);
        check("rst_dir",    64'(bus.dir),    64'h1);
        check("rst_tc",     64'(bus.tc),     64'h0);
        check("rst_colors", 64'(bus.colors), 64'h09060300);
        @(negedge clk);
        reset = 1'b0;

        // Up count with small wrap
        bus.max_val = 8'd3;
        run(4);
        check("up_wrap_count", 64'(bus.count), 64'h0);
        check("up_wrap_tc",    64'(bus.tc),    64'h1);
        run(2);

        // Reach 5, then reset asynchronously between edges
        bus.max_val = 8'd255;
        run(3);
        check("pre_reset_count", 64'(bus.count), 64'd5);
        #2 reset = 1'b1;
        #1;
        check("async_rst_count",  64'(bus.count),  64'h0);
        check("async_rst_tc",     64'(bus.tc),     64'h0);
        check("async_rst_dir",    64'(bus.dir),    64'h1);
        check("async_rst_colors", 64'(bus.colors), 64'h09060300);
        model_reset();
        #2 reset = 1'b0;

        // Prescaled count with a hold window
        bus.prescale_div = 16'd2;
        run(9);
        check("psc_count", 64'(bus.count), 64'd3);
        held = bus.count;
        bus.hold = 1'b1;
        run(6);
        check("hold_count", 64'(bus.count), 64'(held));
        bus.hold = 1'b0;
        run(6);

        // Bounce from 0 between 0 and 3, then degenerate max_val
        bus.prescale_div = 16'd0;
        bus.load = 1'b1; bus.load_val = 8'h00;
        cycle();
        bus.load = 1'b0;
        bus.mode = 2'd2; bus.max_val = 8'd3;
        run(4);
        check("bounce_turn_dir",   64'(bus.dir),   64'h0);
        check("bounce_turn_count", 64'(bus.count), 64'd2);
        run(6);
        bus.max_val = 8'd0;
        run(4);

        // Load beats hold; mode 1 clamps an out-of-range count without tc
        bus.load = 1'b1; bus.hold = 1'b1; bus.load_val = 8'hA5;
        cycle();
        check("load_prio", 64'(bus.count), 64'hA5);
        bus.load = 1'b0; bus.hold = 1'b0;
        bus.mode = 2'd1; bus.max_val = 8'h10;
        cycle();
        check("down_clamp_count", 64'(bus.count), 64'h10);
        check("down_clamp_tc",    64'(bus.tc),    64'h0);
        run(20);

        // LFSR sequencing, lock-up escape and full period
        bus.load = 1'b1; bus.load_val = 8'h01;
        cycle();
        bus.load = 1'b0; bus.mode = 2'd3;
        cycle();
        check("lfsr_s1", 64'(bus.count), 64'hB8);
        cycle();
        check("lfsr_s2", 64'(bus.count), 64'h5C);
        bus.load = 1'b1; bus.load_val = 8'h00;
        cycle();
        bus.load = 1'b0;
        cycle();
        check("lfsr_escape", 64'(bus.count), 64'h01);
        tcs = 0;
        for (int i = 0; i < 255; i++) begin
            cycle();
            if (bus.tc) tcs++;
        end
        check("lfsr_period_count", 64'(bus.count), 64'h01);
        check("lfsr_period_tcs",   64'(tcs),       64'd1);

        // Randomised mixed traffic
        for (int i = 0; i < 300; i++) begin
            bus.mode         = 2'($urandom_range(0, 3));
            bus.hold         = ($urandom_range(0, 7) == 0);
            bus.load         = ($urandom_range(0, 15) == 0);
            bus.load_val     = 8'($urandom);
            bus.max_val      = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 12));
            bus.prescale_div = 16'($urandom_range(0, 3));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
